// File: rtl/serial_magnitude_accumulator.sv
// serial_magnitude_accumulator
//   Folds a stream of per-digit gt/eq/lt flags (MSB digit first) into the
//   magnitude relation of a full 2*NUM_DIGITS-bit word. The first non-equal
//   digit decides the word. Digits whose flags are not one-hot raise a sticky
//   error and are treated as equal.
//
// Ports
//   clk, rst        rising-edge clock, async active-high reset
//   flush           synchronous abort of partial word / held result
//   in_valid/ready  digit handshake; dig_gt/eq/lt are the digit flags
//   res_valid/ready result handshake; res_gt/eq/lt/err are the word result
//   dig_cnt         digits accepted so far in the current word
module serial_magnitude_accumulator #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          dig_gt,
  input  logic                          dig_eq,
  input  logic                          dig_lt,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          res_gt,
  output logic                          res_eq,
  output logic                          res_lt,
  output logic                          res_err,
  output logic [$clog2(NUM_DIGITS)-1:0] dig_cnt
);

  localparam int CNT_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic {S_COLLECT, S_HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_dig_cnt;
  logic             r_decided, r_dec_gt, r_err_acc;
  logic             r_res_valid, r_res_gt, r_res_eq, r_res_lt, r_res_err;

  logic w_accept, w_last, w_onehot, w_hshake;
  logic w_decided_nxt, w_dec_gt_nxt, w_err_nxt;

  assign in_ready = (r_state == S_COLLECT);
  assign w_accept = in_valid & in_ready;
  assign w_last   = w_accept & (r_dig_cnt == LAST_DIG);
  assign w_hshake = (r_state == S_HOLD) & r_res_valid & res_ready;

  // Malformed flag patterns count as an equal digit so they never decide.
  assign w_onehot = ( dig_gt & ~dig_eq & ~dig_lt) |
                    (~dig_gt &  dig_eq & ~dig_lt) |
                    (~dig_gt & ~dig_eq &  dig_lt);

  // Once decided, later digits are ignored: MSB-first, first difference wins.
  assign w_decided_nxt = r_decided | (w_onehot & (dig_gt | dig_lt));
  assign w_dec_gt_nxt  = r_decided ? r_dec_gt : (w_onehot & dig_gt);
  assign w_err_nxt     = r_err_acc | ~w_onehot;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (w_last)   w_state_nxt = S_HOLD;
      S_HOLD:    if (w_hshake) w_state_nxt = S_COLLECT;
      default:                 w_state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_state <= S_COLLECT;
    else if (flush) r_state <= S_COLLECT;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dig_cnt   <= '0;
      r_decided   <= 1'b0;
      r_dec_gt    <= 1'b0;
      r_err_acc   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_gt    <= 1'b0;
      r_res_eq    <= 1'b0;
      r_res_lt    <= 1'b0;
      r_res_err   <= 1'b0;
    end else if (flush) begin
      r_dig_cnt   <= '0;
      r_decided   <= 1'b0;
      r_dec_gt    <= 1'b0;
      r_err_acc   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_gt    <= 1'b0;
      r_res_eq    <= 1'b0;
      r_res_lt    <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dig_cnt <= w_last ? '0 : r_dig_cnt + CNT_W'(1);
        r_decided <= w_decided_nxt;
        r_dec_gt  <= w_dec_gt_nxt;
        r_err_acc <= w_err_nxt;
      end
      // Result captures the last digit's contribution on the same edge.
      if (w_last) begin
        r_res_valid <= 1'b1;
        r_res_gt    <= w_decided_nxt &  w_dec_gt_nxt;
        r_res_lt    <= w_decided_nxt & ~w_dec_gt_nxt;
        r_res_eq    <= ~w_decided_nxt;
        r_res_err   <= w_err_nxt;
      end
      if (w_hshake) begin
        r_decided   <= 1'b0;
        r_dec_gt    <= 1'b0;
        r_err_acc   <= 1'b0;
        r_res_valid <= 1'b0;
        r_res_gt    <= 1'b0;
        r_res_eq    <= 1'b0;
        r_res_lt    <= 1'b0;
        r_res_err   <= 1'b0;
      end
    end
  end

  assign dig_cnt   = r_dig_cnt;
  assign res_valid = r_res_valid;
  assign res_gt    = r_res_gt;
  assign res_eq    = r_res_eq;
  assign res_lt    = r_res_lt;
  assign res_err   = r_res_err;

endmodule

// File: tb/tb_serial_magnitude_accumulator.sv
module tb_serial_magnitude_accumulator;
  localparam int N  = 4;
  localparam int W  = 2 * N;
  localparam int CW = $clog2(N);

  logic clk, rst, flush, in_valid, in_ready, dig_gt, dig_eq, dig_lt;
  logic res_valid, res_ready, res_gt, res_eq, res_lt, res_err;
  logic [CW-1:0] dig_cnt;

  serial_magnitude_accumulator #(.NUM_DIGITS(N)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .dig_gt(dig_gt), .dig_eq(dig_eq), .dig_lt(dig_lt),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_gt(res_gt), .res_eq(res_eq), .res_lt(res_lt), .res_err(res_err),
    .dig_cnt(dig_cnt)
  );

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];   // {gt,eq,lt,err}
  int exp_cnt = 0;
  int rr_mode = 0;        // 0 random, 1 hold low, 2 hold high

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the word relation is plain unsigned compare, with any digit
  // carrying bad flags forced equal on both sides.
  function automatic logic [3:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [N-1:0] bad);
    logic [W-1:0] bm;
    bm = b;
    for (int i = 0; i < N; i++)
      if (bad[i]) bm[2*(N-1-i) +: 2] = a[2*(N-1-i) +: 2];
    return {a > bm, a == bm, a < bm, |bad};
  endfunction

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       res_ready = 1'($urandom_range(0, 1));
      1:       res_ready = 1'b0;
      default: res_ready = 1'b1;
    endcase
  end

  always @(posedge rst) exp_cnt = 0;

  // Monitor: checks count, handshake invariant and results at every negedge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("dig_cnt", 32'(dig_cnt), 32'(exp_cnt));
      chk("in_ready", 32'(in_ready), 32'(!res_valid));
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_result: res_valid=1 with no expected word at %0t", $time);
        end else begin
          chk("result", 32'({res_gt, res_eq, res_lt, res_err}), 32'(exp_q[0]));
          if (res_ready && !flush) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_res", 32'({res_gt, res_eq, res_lt, res_err}), 32'd0);
      end
      if (flush) exp_cnt = 0;
      else if (in_valid && in_ready) exp_cnt = (exp_cnt + 1) % N;
    end
  end

  // Presents one digit and waits until it is taken; leaves at posedge+1.
  task automatic drive_digit(input logic [1:0] a, input logic [1:0] b,
                             input logic bad, input logic [2:0] pat);
    int to;
    logic [2:0] bads [5];
    bads = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    to = 0;
    in_valid = 1'b1;
    if (bad) {dig_gt, dig_eq, dig_lt} = (pat != 3'b000) ? pat : bads[$urandom_range(0, 4)];
    else     {dig_gt, dig_eq, dig_lt} = {a > b, a == b, a < b};
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++to > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready=0 for 200 cycles at %0t", $time);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    {dig_gt, dig_eq, dig_lt} = 3'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // gap: 0 back-to-back, 1 alternate, 2 random idle cycles between digits.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [N-1:0] bad, input logic [2:0] pat,
                           input int ndig, input int gap);
    if (ndig == N) exp_q.push_back(ref_result(a, b, bad));
    for (int i = 0; i < ndig; i++) begin
      drive_digit(a[2*(N-1-i) +: 2], b[2*(N-1-i) +: 2], bad[i], pat);
      if (gap == 1) idle(1);
      else if (gap == 2) idle($urandom_range(0, 2));
    end
  endtask

  task automatic wait_drain();
    int to;
    to = 0;
    while (exp_q.size() != 0 && to < 500) begin @(posedge clk); #1; to++; end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; res_ready = 0;
    {dig_gt, dig_eq, dig_lt} = 3'b000;
    #3;
    chk("rst_cnt", 32'(dig_cnt), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_res", 32'({res_gt, res_eq, res_lt, res_err}), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    idle(2);
    rst = 0;
    idle(1);

    rr_mode = 2;
    send_word(8'b10_01_11_00, 8'b10_01_10_11, '0, 3'b000, N, 0);
    wait_drain();
    send_word(8'hA5, 8'hA5, '0, 3'b000, N, 0);
    send_word(8'h3F, 8'hC0, '0, 3'b000, N, 0);
    wait_drain();

    // Backpressure: result held, offered digits must not be consumed.
    rr_mode = 1;
    send_word(8'h12, 8'h34, '0, 3'b000, N, 0);
    while (!res_valid) begin @(posedge clk); #1; end
    in_valid = 1'b1; {dig_gt, dig_eq, dig_lt} = 3'b100;
    idle(3);
    in_valid = 1'b0;
    rr_mode = 2;
    wait_drain();

    // Bad flags on digit 2 (gt and lt together), then a clean word.
    send_word(8'h5A, 8'h5A, 4'b0100, 3'b101, N, 0);
    send_word(8'h5A, 8'h5A, '0, 3'b000, N, 0);
    wait_drain();

    rr_mode = 0;
    send_word(8'hC3, 8'hC7, '0, 3'b000, N, 1);
    wait_drain();

    // Flush after a decided gt prefix; the flush-cycle digit is dropped.
    send_word(8'hF0, 8'h00, '0, 3'b000, 2, 0);
    flush = 1'b1; in_valid = 1'b1; {dig_gt, dig_eq, dig_lt} = 3'b100;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    send_word(8'h66, 8'h66, '0, 3'b000, N, 0);
    wait_drain();

    // Asynchronous reset mid-cycle after a decided gt prefix.
    send_word(8'hF0, 8'h00, '0, 3'b000, 2, 0);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    send_word(8'h99, 8'h99, '0, 3'b000, N, 0);
    wait_drain();

    for (int w = 0; w < 40; w++) begin
      logic [W-1:0] a, b;
      logic [N-1:0] bad;
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      bad = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      send_word(a, b, bad, 3'b000, N, 2);
    end
    wait_drain();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
